// File: rtl/raycast_fix_pkg.sv
// raycast_fix_pkg: shared fixed-point helpers, seed-table generator and FSM state type for the raycaster.
package raycast_fix_pkg;
    typedef enum logic [2:0] {IDLE, SEED, SQ, HX, UPD, FIN, DONE} state_t;
    localparam real SQRT2 = 1.4142135623730951;
    function automatic logic signed [63:0] fix_mul_sat(input logic signed [63:0] a, input logic signed [63:0] b, input int w, input int f);
        logic signed [127:0] p, mx;
        p = (128'(a) * 128'(b)) >>> f;
        mx = (128'sd1 <<< (w - 1)) - 128'sd1;
        return (p > mx) ? 64'(mx) : (p < -mx - 128'sd1) ? 64'(-mx - 128'sd1) : 64'(p);
    endfunction
    function automatic logic signed [63:0] three_halfs(input int frac);
        return 64'sd3 <<< (frac - 1);
    endfunction
    // 2^FRAC / sqrt(2^(p-FRAC)) == 2^((3*FRAC-p)/2), built from exact doublings plus one sqrt(2) for odd exponents
    function automatic logic signed [63:0] seed_val(input int p, input int frac, input int w);
        real r, lim;
        int e;
        e = 3 * frac - p;
        r = (e % 2 != 0) ? SQRT2 : 1.0;
        for (int i = 0; i < (e >>> 1); i++) r = r * 2.0;
        for (int i = (e >>> 1); i < 0; i++) r = r / 2.0;
        lim = 1.0;
        for (int i = 1; i < w; i++) lim = lim * 2.0;
        return (r + 0.5 >= lim) ? (64'sd1 <<< (w - 1)) - 64'sd1 : 64'(longint'(r));
    endfunction
endpackage

// File: rtl/inv_sqrt_iter_if.sv
// inv_sqrt_iter_if: operand/result valid-ready bundle for the reciprocal square root unit.
interface inv_sqrt_iter_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, in_mode, out_valid, out_ready, out_err;
    logic signed [WIDTH-1:0] in_x, out_result;
    modport master (output in_valid, in_x, in_mode, out_ready, input in_ready, out_valid, out_result, out_err);
    modport slave (input in_valid, in_x, in_mode, out_ready, output in_ready, out_valid, out_result, out_err);
endinterface

// File: rtl/fix_mul.sv
// fix_mul: combinational signed fixed-point multiply, floor shift by FRAC and saturate to WIDTH.
module fix_mul
    import raycast_fix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_p
);
    assign o_p = WIDTH'(fix_mul_sat(64'(i_a), 64'(i_b), WIDTH, FRAC));
endmodule

// File: rtl/inv_sqrt_iter.sv
// inv_sqrt_iter: multi-cycle x^-1/2 or sqrt(x) by Newton-Raphson on one shared multiplier.
module inv_sqrt_iter
    import raycast_fix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ITERS = 4
) (
    input logic clk,
    input logic rst,
    inv_sqrt_iter_if.slave bus
);
    localparam int PW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] TH = WIDTH'(three_halfs(FRAC));
    state_t r_state, w_next;
    logic signed [WIDTH-1:0] r_x, r_xh, r_g, r_t, r_result;
    logic r_mode, r_err, r_valid;
    logic [3:0] r_k;
    logic [PW-1:0] w_p;
    logic signed [WIDTH-1:0] w_seed_tab [WIDTH-1];
    logic signed [WIDTH:0] w_diff;
    logic signed [WIDTH-1:0] w_sub, w_a, w_b, w_prod;
    logic w_last, w_in_ready;
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_seed
        localparam logic signed [WIDTH-1:0] S = WIDTH'(seed_val(i, FRAC, WIDTH));
        assign w_seed_tab[i] = S;
    end
    always_comb begin
        w_p = '0;
        for (int i = 0; i < WIDTH - 1; i++) if (r_x[i]) w_p = PW'(i);
    end
    always_comb begin
        w_diff = {TH[WIDTH-1], TH} - {r_t[WIDTH-1], r_t};
        w_sub = (w_diff[WIDTH] != w_diff[WIDTH-1]) ? (w_diff[WIDTH] ? MINV : MAXV) : w_diff[WIDTH-1:0];
        w_last = (r_k == 4'(ITERS - 1));
    end
    fix_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.i_a(w_a), .i_b(w_b), .o_p(w_prod));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_result <= '0;
            r_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (r_state == DONE) && (w_next == DONE);
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_x <= bus.in_x;
                    r_xh <= bus.in_x >>> 1;
                    r_mode <= bus.in_mode;
                end
                SEED: begin
                    r_g <= w_seed_tab[w_p];
                    r_k <= '0;
                    if (r_x == '0) begin
                        r_result <= r_mode ? '0 : MAXV;
                        r_err <= !r_mode;
                    end else if (r_x[WIDTH-1]) begin
                        r_result <= '0;
                        r_err <= 1'b1;
                    end
                end
                SQ, HX: r_t <= w_prod;
                UPD: begin
                    r_g <= w_prod;
                    r_k <= r_k + 4'd1;
                    if (w_last && !r_mode) begin
                        r_result <= w_prod;
                        r_err <= 1'b0;
                    end
                end
                FIN: begin
                    r_result <= w_prod;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    // out_valid lags entry into DONE by one edge, so the handshake only counts once it is visible
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = bus.in_valid ? SEED : IDLE;
            SEED: w_next = (r_x == '0 || r_x[WIDTH-1]) ? DONE : SQ;
            SQ: w_next = HX;
            HX: w_next = UPD;
            UPD: w_next = !w_last ? SQ : (r_mode ? FIN : DONE);
            FIN: w_next = DONE;
            DONE: w_next = (r_valid && bus.out_ready) ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_in_ready = (r_state == IDLE);
        w_a = (r_state == HX) ? r_xh : (r_state == FIN) ? r_x : r_g;
        w_b = (r_state == HX) ? r_t : (r_state == UPD) ? w_sub : r_g;
    end
    assign bus.in_ready = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_err = r_err;
endmodule

// File: tb/tb_inv_sqrt_iter.sv
// tb_inv_sqrt_iter: directed and random checks of inv_sqrt_iter against a Newton-Raphson reference model.
module tb_inv_sqrt_iter;
    localparam int WIDTH = 32, FRAC = 16, ITERS = 4;
    localparam longint MAXV = (64'sd1 <<< 31) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< 31);
    localparam longint TH = 64'sd98304;
    logic clk, rst;
    int checks = 0, errors = 0;
    longint res, hold_res, eres;
    bit err, eerr, stable, rdy_low, seen;
    int lat, elat, n;
    inv_sqrt_iter_if #(.WIDTH(WIDTH)) bus();
    inv_sqrt_iter #(.WIDTH(WIDTH), .FRAC(FRAC), .ITERS(ITERS)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
    endfunction
    function automatic longint mulq(input longint a, input longint b);
        return sat((a * b) >>> FRAC);
    endfunction
    function automatic void ref_model(input longint x, input bit m, output longint r, output bit e, output int l);
        longint g;
        int p;
        if (x <= 0) begin
            r = (x == 0 && !m) ? MAXV : 0;
            e = (x < 0) || !m;
            l = 2;
            return;
        end
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        g = longint'($rtoi(2.0 ** ((3.0 * FRAC - p) / 2.0) + 0.5));
        for (int i = 0; i < ITERS; i++) g = mulq(g, sat(TH - mulq(x >>> 1, mulq(g, g))));
        r = m ? mulq(x, g) : g;
        e = 1'b0;
        l = 3 * ITERS + 2 + int'(m);
    endfunction
    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_tol(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs - exp <= 4 && exp - obs <= 4) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h+-4", tag, obs, exp);
        end
    endtask
    task automatic wait_done(output longint r, output bit e, output int l);
        l = 0;
        while (!bus.out_valid && l < 100) begin
            @(negedge clk);
            l++;
        end
        r = longint'(bus.out_result);
        e = bus.out_err;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask
    task automatic start_op(input logic [31:0] x, input bit m);
        int k;
        @(negedge clk);
        bus.in_x = x;
        bus.in_mode = m;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
    endtask
    task automatic cmp_model(input logic [31:0] x, input bit m, input string tag, output longint r);
        longint er;
        bit e, ee;
        int l, el;
        start_op(x, m);
        bus.in_valid = 1'b0;
        wait_done(r, e, l);
        ref_model(longint'(signed'(x)), m, er, ee, el);
        check({tag, "_res"}, r, er);
        check({tag, "_err"}, longint'(e), longint'(ee));
        check({tag, "_lat"}, longint'(l), longint'(el));
    endtask
    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_mode = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_result", longint'(bus.out_result), 0);
        check("rst_out_err", longint'(bus.out_err), 0);
        rst = 1'b0;
        cmp_model(32'h0001_0000, 1'b0, "one_inv", res);
        check_tol("one_inv_ideal", res, 64'h1_0000);
        cmp_model(32'h0004_0000, 1'b0, "four_inv", res);
        check_tol("four_inv_ideal", res, 64'h8000);
        cmp_model(32'h0004_0000, 1'b1, "four_sqrt", res);
        check_tol("four_sqrt_ideal", res, 64'h2_0000);
        cmp_model(32'h0, 1'b0, "zero_inv", res);
        cmp_model(32'h0, 1'b1, "zero_sqrt", res);
        cmp_model(32'hFFFF_0000, 1'b0, "neg_inv", res);
        cmp_model(32'hFFFF_0000, 1'b1, "neg_sqrt", res);
        // back-pressure: result held while in_valid stays high for the next operand
        start_op(32'h0004_0000, 1'b0);
        bus.in_x = 32'h0009_0000;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold_res = longint'(bus.out_result);
        stable = 1'b1;
        rdy_low = !bus.in_ready;
        repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid || longint'(bus.out_result) !== hold_res) stable = 1'b0;
            if (bus.in_ready) rdy_low = 1'b0;
        end
        ref_model(64'h4_0000, 1'b0, eres, eerr, elat);
        check("hold_stable", longint'(stable), 1);
        check("hold_ready_low", longint'(rdy_low), 1);
        check("hold_res", hold_res, eres);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("hs_valid_drop", longint'(bus.out_valid), 0);
        check("hs_idle_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
        check("next_accepted", longint'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        wait_done(res, err, lat);
        ref_model(64'h9_0000, 1'b0, eres, eerr, elat);
        check("next_res", res, eres);
        check("next_lat", longint'(lat), longint'(elat));
        // reset in the fifth cycle of an operation abandons it
        start_op(32'h0004_0000, 1'b1);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", longint'(bus.in_ready), 1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_mid_no_valid", longint'(seen), 0);
        cmp_model(32'h0009_0000, 1'b0, "nine_inv", res);
        check_tol("nine_inv_ideal", res, 64'h5555);
        for (int k = 0; k <= 30; k++)
            for (int m = 0; m <= 1; m++)
                cmp_model(32'd1 << k, m[0], $sformatf("sweep_k%0d_m%0d", k, m), res);
        cmp_model(32'h7FFF_FFFF, 1'b0, "max_inv", res);
        cmp_model(32'h7FFF_FFFF, 1'b1, "max_sqrt", res);
        cmp_model(32'h0000_0001, 1'b1, "min_sqrt", res);
        for (int i = 0; i < 24; i++)
            cmp_model($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i), res);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
